// File: rtl/olive_servo_ctrl.sv
// Eight-channel servo pulse scheduler with Avalon-MM register file.
// Pending settings are committed atomically at the next frame boundary.
module olive_servo_ctrl #(
    parameter int unsigned PRESCALE   = 100,
    parameter int unsigned DEF_PERIOD = 20000,
    parameter int unsigned DEF_WIDTH  = 1500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        ins_irq,
    output logic [7:0]  servo_pwm
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [15:0] DEF_P    = 16'(DEF_PERIOD);
    localparam logic [15:0] DEF_W    = 16'(DEF_WIDTH);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] pend_width_q [8];
    logic [15:0] pend_width_d [8];
    logic [15:0] act_width_q [8];
    logic [15:0] act_width_d [8];
    logic [15:0] pend_period_q, pend_period_d;
    logic [15:0] act_period_q, act_period_d;
    logic [7:0]  pend_en_q, pend_en_d;
    logic [7:0]  act_en_q, act_en_d;
    logic        commit_pend_q, commit_pend_d;
    logic        irq_en_q, irq_en_d;
    logic        frame_flag_q, frame_flag_d;
    logic [7:0]  pwm_q, pwm_d;
    logic [31:0] rdata_q, rdata_d;

    logic tick, frame_last, boundary;
    logic unused_wdata;

    assign unused_wdata = ^{avs_writedata[31:17], avs_writedata[15:9]};

    always_comb begin
        pre_cnt_d     = pre_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        pend_width_d  = pend_width_q;
        act_width_d   = act_width_q;
        pend_period_d = pend_period_q;
        act_period_d  = act_period_q;
        pend_en_d     = pend_en_q;
        act_en_d      = act_en_q;
        commit_pend_d = commit_pend_q;
        irq_en_d      = irq_en_q;
        frame_flag_d  = frame_flag_q;
        pwm_d         = '0;
        rdata_d       = '0;

        tick        = (pre_cnt_q == PRE_LAST);
        frame_last  = (frame_cnt_q == act_period_q - 16'd1);
        boundary    = tick && frame_last;
        pre_cnt_d   = tick ? 16'd0 : pre_cnt_q + 16'd1;
        if (tick) begin
            frame_cnt_d = frame_last ? 16'd0 : frame_cnt_q + 16'd1;
        end

        // Copy uses the registered pending values, so same-cycle writes land next time.
        if (boundary && commit_pend_q) begin
            act_width_d   = pend_width_q;
            act_period_d  = (pend_period_q < 16'd2) ? 16'd2 : pend_period_q;
            act_en_d      = pend_en_q;
            commit_pend_d = 1'b0;
        end

        if (avs_write) begin
            case (avs_address)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
                    pend_width_d[avs_address[2:0]] = avs_writedata[15:0];
                4'h8: pend_period_d = avs_writedata[15:0];
                4'h9: begin
                    pend_en_d = avs_writedata[7:0];
                    irq_en_d  = avs_writedata[16];
                    if (avs_writedata[8]) commit_pend_d = 1'b1;
                end
                4'hA: if (avs_writedata[0]) frame_flag_d = 1'b0;
                default: ;
            endcase
        end
        if (boundary) frame_flag_d = 1'b1;

        for (int n = 0; n < 8; n++) begin
            pwm_d[n] = act_en_d[n] && (frame_cnt_d < act_width_d[n]);
        end

        if (avs_read) begin
            case (avs_address)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
                    rdata_d = {16'd0, pend_width_q[avs_address[2:0]]};
                4'h8: rdata_d = {16'd0, pend_period_q};
                4'h9: rdata_d = {15'd0, irq_en_q, 7'd0, commit_pend_q, pend_en_q};
                4'hA: rdata_d = {frame_cnt_q, 15'd0, frame_flag_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            for (int n = 0; n < 8; n++) begin
                pend_width_q[n] <= DEF_W;
                act_width_q[n]  <= DEF_W;
            end
            pend_period_q <= DEF_P;
            act_period_q  <= DEF_P;
            pend_en_q     <= '0;
            act_en_q      <= '0;
            commit_pend_q <= 1'b0;
            irq_en_q      <= 1'b0;
            frame_flag_q  <= 1'b0;
            pwm_q         <= '0;
            rdata_q       <= '0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            pend_width_q  <= pend_width_d;
            act_width_q   <= act_width_d;
            pend_period_q <= pend_period_d;
            act_period_q  <= act_period_d;
            pend_en_q     <= pend_en_d;
            act_en_q      <= act_en_d;
            commit_pend_q <= commit_pend_d;
            irq_en_q      <= irq_en_d;
            frame_flag_q  <= frame_flag_d;
            pwm_q         <= pwm_d;
            rdata_q       <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign ins_irq      = frame_flag_q && irq_en_q;
    assign servo_pwm    = pwm_q;

endmodule
